// File: rtl/topk_pkg.sv
// Shared definitions for the top-k feeder: parameter defaults and FSM state encoding.
// Imported by the feeder RTL and its testbench.
package topk_pkg;

    localparam int DEF_DATA_WIDTH   = 4;
    localparam int DEF_INDEX_WIDTH  = 9;
    localparam int DEF_TOP_K_NUMBER = 30;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/topk_feeder_if.sv
// Bundle of the feeder's row-control, score-stream and chain-head signals.
// The feeder keeps flat ports; this bundle connects producers/consumers to them.
interface topk_feeder_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int INDEX_WIDTH = 9
);
    logic                   i_start;
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_WIDTH-1:0]  s_data;
    logic                   s_last;
    logic                   i_ack;
    logic                   o_valid;
    logic [DATA_WIDTH-1:0]  o_data;
    logic [INDEX_WIDTH:0]   o_index;
    logic                   o_clear;
    logic                   o_done;
    logic [INDEX_WIDTH:0]   o_count;
    logic                   o_overflow;

    // Producer / controller side.
    modport master (
        output i_start, s_valid, s_data, s_last, i_ack,
        input  s_ready, o_valid, o_data, o_index, o_clear, o_done, o_count, o_overflow
    );

    // Feeder side.
    modport slave (
        input  i_start, s_valid, s_data, s_last, i_ack,
        output s_ready, o_valid, o_data, o_index, o_clear, o_done, o_count, o_overflow
    );
endinterface

// File: rtl/topk_feeder.sv
// Feeds one row of signed scores into a top-k sort-PE chain: clears the chain, tags each
// score with its index, then waits for the last beat to ripple through every PE.
module topk_feeder
    import topk_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int TOP_K_NUMBER = DEF_TOP_K_NUMBER
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_last,
    input  logic                   i_ack,
    output logic                   o_valid,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [INDEX_WIDTH:0]   o_index,
    output logic                   o_clear,
    output logic                   o_done,
    output logic [INDEX_WIDTH:0]   o_count,
    output logic                   o_overflow
);

    localparam int CW      = INDEX_WIDTH + 1;
    localparam int DRAIN_W = $clog2(TOP_K_NUMBER + 1);

    state_e              state_q, state_d;
    logic                s_ready_q, s_ready_d;
    logic                o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [CW-1:0]       o_index_q, o_index_d;
    logic                o_clear_q, o_clear_d;
    logic                o_done_q, o_done_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    always_comb begin
        state_d    = state_q;
        o_valid_d  = 1'b0;
        o_data_d   = o_data_q;
        o_index_d  = o_index_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drain_d    = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_CLEAR;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    drain_d    = '0;
                end
            end
            ST_CLEAR: state_d = ST_STREAM;
            ST_STREAM: begin
                if (s_valid) begin
                    // count_q doubles as the next index; its MSB means the index space is used up.
                    if (!count_q[INDEX_WIDTH]) begin
                        o_valid_d = 1'b1;
                        o_data_d  = s_data;
                        o_index_d = {1'b0, count_q[INDEX_WIDTH-1:0]};
                        count_d   = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (s_last) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_W'(TOP_K_NUMBER);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q != '0) drain_d = drain_q - DRAIN_W'(1);
                // Leave as the counter reaches zero so o_done rises TOP_K_NUMBER cycles after the last o_valid.
                if (drain_q <= DRAIN_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (i_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_STREAM);
        o_clear_d = (state_d == ST_CLEAR);
        o_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_ready_q  <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_index_q  <= '0;
            o_clear_q  <= 1'b0;
            o_done_q   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            s_ready_q  <= s_ready_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_index_q  <= o_index_d;
            o_clear_q  <= o_clear_d;
            o_done_q   <= o_done_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drain_q    <= drain_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_index    = o_index_q;
    assign o_clear    = o_clear_q;
    assign o_done     = o_done_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_topk_feeder.sv
// Directed bench for topk_feeder: a default-size instance plus a 2-bit-index instance for overflow.
module tb_topk_feeder;
    import topk_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    topk_feeder_if #(.DATA_WIDTH(4), .INDEX_WIDTH(9)) fa ();
    topk_feeder_if #(.DATA_WIDTH(4), .INDEX_WIDTH(2)) fb ();

    topk_feeder dut_a (
        .clk(clk), .rst(rst),
        .i_start(fa.i_start), .s_valid(fa.s_valid), .s_ready(fa.s_ready),
        .s_data(fa.s_data), .s_last(fa.s_last), .i_ack(fa.i_ack),
        .o_valid(fa.o_valid), .o_data(fa.o_data), .o_index(fa.o_index),
        .o_clear(fa.o_clear), .o_done(fa.o_done), .o_count(fa.o_count),
        .o_overflow(fa.o_overflow)
    );

    topk_feeder #(.DATA_WIDTH(4), .INDEX_WIDTH(2), .TOP_K_NUMBER(3)) dut_b (
        .clk(clk), .rst(rst),
        .i_start(fb.i_start), .s_valid(fb.s_valid), .s_ready(fb.s_ready),
        .s_data(fb.s_data), .s_last(fb.s_last), .i_ack(fb.i_ack),
        .o_valid(fb.o_valid), .o_data(fb.o_data), .o_index(fb.o_index),
        .o_clear(fb.o_clear), .o_done(fb.o_done), .o_count(fb.o_count),
        .o_overflow(fb.o_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, ".s_ready"},  32'(fa.s_ready),    32'd0);
        chk({pfx, ".o_valid"},  32'(fa.o_valid),    32'd0);
        chk({pfx, ".o_data"},   32'(fa.o_data),     32'd0);
        chk({pfx, ".o_index"},  32'(fa.o_index),    32'd0);
        chk({pfx, ".o_clear"},  32'(fa.o_clear),    32'd0);
        chk({pfx, ".o_done"},   32'(fa.o_done),     32'd0);
        chk({pfx, ".o_count"},  32'(fa.o_count),    32'd0);
        chk({pfx, ".o_ovf"},    32'(fa.o_overflow), 32'd0);
    endtask

    // Start a row on instance A: one CLEAR cycle, then STREAM with s_ready high.
    task automatic start_row_a(input string pfx);
        fa.i_start = 1'b1;
        step();
        chk({pfx, ".clear"}, 32'(fa.o_clear), 32'd1);
        chk({pfx, ".cnt0"},  32'(fa.o_count), 32'd0);
        fa.i_start = 1'b0;
        step();
        chk({pfx, ".clear_off"}, 32'(fa.o_clear), 32'd0);
        chk({pfx, ".ready"},     32'(fa.s_ready), 32'd1);
    endtask

    task automatic wait_done(input bit sel_b, input int exp, input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (sel_b ? fb.o_done : fa.o_done) break;
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    logic [3:0] vec_a [5] = '{4'd3, 4'hE, 4'd7, 4'd0, 4'd1};
    logic       tog   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int idx;
        fa.i_start = 0; fa.s_valid = 0; fa.s_data = '0; fa.s_last = 0; fa.i_ack = 0;
        fb.i_start = 0; fb.s_valid = 0; fb.s_data = '0; fb.s_last = 0; fb.i_ack = 0;

        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;

        // Five-beat row 3,-2,7,0,1.
        start_row_a("r1");
        for (int k = 0; k < 5; k++) begin
            fa.s_valid = 1'b1; fa.s_data = vec_a[k]; fa.s_last = (k == 4);
            step();
            chk($sformatf("r1.valid%0d", k), 32'(fa.o_valid), 32'd1);
            chk($sformatf("r1.data%0d", k),  32'(fa.o_data),  32'(vec_a[k]));
            chk($sformatf("r1.index%0d", k), 32'(fa.o_index), 32'(k));
        end
        fa.s_valid = 1'b0; fa.s_last = 1'b0;
        fa.i_start = 1'b1;
        step();
        chk("r1.drain_noready", 32'(fa.s_ready), 32'd0);
        chk("r1.drain_novalid", 32'(fa.o_valid), 32'd0);
        wait_done(1'b0, 29, "r1.done_latency");
        chk("r1.count", 32'(fa.o_count), 32'd5);
        step(); step();
        fa.i_start = 1'b0;
        chk("r1.done_held", 32'(fa.o_done), 32'd1);
        fa.i_ack = 1'b1;
        step();
        fa.i_ack = 1'b0;
        chk("r1.ack_done_off", 32'(fa.o_done), 32'd0);
        chk("r1.count_held",   32'(fa.o_count), 32'd5);
        step();
        chk("r1.idle_noclear", 32'(fa.o_clear), 32'd0);

        // Gapped input with i_ack asserted during STREAM.
        start_row_a("r2");
        fa.i_ack = 1'b1;
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            fa.s_valid = tog[k]; fa.s_data = 4'(k + 2); fa.s_last = (k == 4);
            step();
            chk($sformatf("r2.valid%0d", k), 32'(fa.o_valid), 32'(tog[k]));
            if (tog[k]) begin
                chk($sformatf("r2.index%0d", k), 32'(fa.o_index), 32'(idx));
                idx++;
            end
        end
        fa.s_valid = 1'b0; fa.s_last = 1'b0; fa.i_ack = 1'b0;
        wait_done(1'b0, 30, "r2.done_latency");
        chk("r2.count", 32'(fa.o_count), 32'd3);
        fa.i_ack = 1'b1; step(); fa.i_ack = 1'b0;

        // Single-beat row of -8.
        start_row_a("r3");
        fa.s_valid = 1'b1; fa.s_data = 4'h8; fa.s_last = 1'b1;
        step();
        fa.s_valid = 1'b0; fa.s_last = 1'b0;
        chk("r3.valid", 32'(fa.o_valid), 32'd1);
        chk("r3.data",  32'(fa.o_data),  32'h8);
        chk("r3.index", 32'(fa.o_index), 32'd0);
        wait_done(1'b0, 30, "r3.done_latency");
        chk("r3.count", 32'(fa.o_count), 32'd1);
        fa.i_ack = 1'b1; step(); fa.i_ack = 1'b0;

        // Overflow on the 2-bit-index instance: six beats, last two dropped.
        fb.i_start = 1'b1; step(); fb.i_start = 1'b0;
        chk("ov.clear", 32'(fb.o_clear), 32'd1);
        step();
        chk("ov.ready", 32'(fb.s_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            fb.s_valid = 1'b1; fb.s_data = 4'(k + 1); fb.s_last = (k == 5);
            step();
            chk($sformatf("ov.valid%0d", k), 32'(fb.o_valid), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) chk($sformatf("ov.index%0d", k), 32'(fb.o_index), 32'(k));
        end
        fb.s_valid = 1'b0; fb.s_last = 1'b0;
        chk("ov.overflow", 32'(fb.o_overflow), 32'd1);
        chk("ov.count",    32'(fb.o_count),    32'd4);
        wait_done(1'b1, 3, "ov.done_latency");
        fb.i_ack = 1'b1; step(); fb.i_ack = 1'b0;
        chk("ov.ovf_held", 32'(fb.o_overflow), 32'd1);

        // Reset on the third STREAM cycle, then stimulus without i_start.
        start_row_a("r4");
        fa.s_valid = 1'b1; fa.s_data = 4'd5;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        fa.i_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("noresp.ready%0d", k), 32'(fa.s_ready), 32'd0);
            chk($sformatf("noresp.valid%0d", k), 32'(fa.o_valid), 32'd0);
            chk($sformatf("noresp.clear%0d", k), 32'(fa.o_clear), 32'd0);
        end
        fa.s_valid = 1'b0; fa.i_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/topk_feeder.md
TOPK_FEEDER -- requirements
Module: topk_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, signed score width.
REQ-002 SHALL have parameter INDEX_WIDTH, default 9, element index width.
REQ-003 SHALL have parameter TOP_K_NUMBER, default 30, number of sort PEs in the downstream chain.
REQ-004 SHALL use one clock; reset is synchronous and active-high: port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_start, input, 1, begin a new row (sampled in IDLE only).
REQ-007 SHALL have port s_valid, input, 1, upstream score valid.
REQ-008 SHALL have port s_ready, output, 1, feeder accepts a score.
REQ-009 SHALL have port s_data, input, DATA_WIDTH, signed score.
REQ-010 SHALL have port s_last, input, 1, final score of the row.
REQ-011 SHALL have port i_ack, input, 1, consumer has read the chain results (sampled in DONE only).
REQ-012 SHALL have port o_valid, output, 1, drives chain-head i_valid.
REQ-013 SHALL have port o_data, output, DATA_WIDTH, drives chain-head i_data.
REQ-014 SHALL have port o_index, output, INDEX_WIDTH+1, drives chain-head i_index; MSB always 0 (all-ones is the chain's empty marker).
REQ-015 SHALL have port o_clear, output, 1, drives i_clear of every PE.
REQ-016 SHALL have port o_done, output, 1, chain results stable and valid.
REQ-017 SHALL have port o_count, output, INDEX_WIDTH+1, scores accepted this row, saturating.
REQ-018 SHALL have port o_overflow, output, 1, sticky: row exceeded 2^INDEX_WIDTH scores.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-020 IDLE: i_start=1 -> CLEAR; i_start outside IDLE SHALL be ignored.
REQ-021 CLEAR: exactly one cycle, o_clear=1; zero o_count, index counter and o_overflow; -> STREAM.
REQ-022 STREAM: s_ready=1; s_ready SHALL be 0 in every other state.
REQ-023 Accepted beat (s_valid&s_ready) SHALL appear on o_valid/o_data/o_index on the next cycle (latency 1, registered); o_valid=0 otherwise.
REQ-024 o_index SHALL be {1'b0, counter}; first beat of a row gets index 0, increments by 1 per accepted beat.
REQ-025 Accepted beat with s_last=1 -> DRAIN; drain counter loaded with TOP_K_NUMBER.
REQ-026 DRAIN: decrement each cycle; at zero -> DONE (last beat has traversed all TOP_K_NUMBER 1-cycle PE stages).
REQ-027 DONE: o_done=1 held; i_ack=1 -> IDLE; i_ack outside DONE SHALL be ignored.
REQ-028 o_count SHALL increment per accepted beat, saturating at 2^INDEX_WIDTH.
REQ-029 Beats accepted once 2^INDEX_WIDTH beats issued SHALL be consumed but not forwarded (o_valid=0) and SHALL set o_overflow; s_last on such a beat still -> DRAIN.
REQ-030 o_count, o_overflow SHALL hold their values through DRAIN, DONE and IDLE until the next CLEAR.
REQ-031 Single-beat row (s_last on first beat) SHALL be legal: index 0 forwarded, then DRAIN.

Reset
REQ-032 rst=1 SHALL force IDLE, s_ready=0, o_valid=0, o_data=0, o_index=0, o_clear=0, o_done=0, o_count=0, o_overflow=0, counters=0, from any state including mid-STREAM.
REQ-033 Reset SHALL NOT assert o_clear; PEs have their own reset.

Structure
REQ-034 Parameter defaults (DATA_WIDTH, INDEX_WIDTH, TOP_K_NUMBER) and FSM state encoding SHALL live in shared package topk_pkg.
REQ-035 No sub-module; FSM, index counter and drain counter ($clog2(TOP_K_NUMBER+1) bits) inline.

Verification
REQ-036 i_start, then 5 beats 3,-2,7,0,1 (last on 1) -> o_clear one cycle; o_index 0..4 one cycle after each accept; o_done exactly 30 cycles after the last beat's o_valid cycle; o_count=5.
REQ-037 s_valid toggling 1,0,1,0 during STREAM -> o_valid gaps mirror input; indices contiguous 0,1,2.
REQ-038 INDEX_WIDTH=2, 6 beats -> indices 0..3 forwarded, beats 5-6 dropped, o_overflow=1, o_count=4.
REQ-039 rst=1 on the 3rd STREAM cycle -> next cycle all outputs 0, state IDLE; i_ack or s_valid without i_start -> no response.
REQ-040 i_start during DRAIN and i_ack during STREAM -> ignored; single-beat row value -8 -> index 0, o_done after 30 drain cycles.
